pagesel_mmu: RTL and testbench

- Parametrised successor to the single-window page selector: WINDOWS independent page registers, each PAGE_W bits wide, programmed over the 8-bit CPU register bus.
- Adds shadow registers with an atomic commit, and a hardware save/restore stack of the full mapping for interrupt entry and exit.
- Sits between the CPU bus decoder and the memory address expander; its outputs drive the upper address bits of each CPU window.

---
 rtl/pagesel_mmu.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_pagesel_mmu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pagesel_mmu.sv
// Multi-window page selector with shadow registers, atomic commit and an
// interrupt save/restore stack. Optional write-protect support: PAGESEL_MMU_WP_EN.
module pagesel_mmu #(
    parameter int PAGE_W      = 5,
    parameter int WINDOWS     = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [4:0]                 AD,
    input  logic [7:0]                 DI,
    output logic [7:0]                 DO,
    input  logic                       rw,
    input  logic                       cs,
    input  logic                       irq_enter,
    input  logic                       irq_exit,
    output logic [WINDOWS*PAGE_W-1:0]  page,
    output logic [WINDOWS-1:0]         wp,
    output logic                       bram_disable
);

    localparam int         MAP_W     = WINDOWS * PAGE_W;
    localparam int         SP_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int         SLOTS     = 1 << SP_W;
    localparam logic [3:0] WIN_CNT   = 4'(WINDOWS);
    localparam logic [2:0] DEPTH     = 3'(STACK_DEPTH);
    localparam logic [4:0] CTRL_AD   = 5'h10;
    localparam logic [4:0] STATUS_AD = 5'h11;

    function automatic logic [11:0] widen(input logic [PAGE_W-1:0] p);
        logic [11:0] f;
        f = 12'h000;
        f[PAGE_W-1:0] = p;
        return f;
    endfunction

    // Replace either the low byte or the high nibble of a page number.
    function automatic logic [PAGE_W-1:0] merge_page(input logic [PAGE_W-1:0] cur,
                                                     input logic              hi,
                                                     input logic [7:0]        data);
        logic [11:0] f;
        f = widen(cur);
        if (hi) begin
            f[11:8] = data[3:0];
        end else begin
            f[7:0] = data;
        end
        return f[PAGE_W-1:0];
    endfunction

    logic [MAP_W-1:0] act_page_r;
    logic [MAP_W-1:0] shd_page_r;
    logic [MAP_W-1:0] act_page_nx_s;
    logic [MAP_W-1:0] shd_page_nx_s;
    logic [MAP_W-1:0] stk_page_r [SLOTS];
    logic [MAP_W-1:0] rd_src_s;

    logic             bram_r;
    logic             shd_mode_r;
    logic [2:0]       cnt_r;
    logic             ovf_r;
    logic             unf_r;
    logic [7:0]       do_r;

    logic             wr_s;
    logic             rd_s;
    logic             page_sel_s;
    logic             hi_sel_s;
    logic [2:0]       win_s;
    logic             enter_s;
    logic             exit_s;
    logic             push_s;
    logic             pop_s;
    logic             ovf_set_s;
    logic             unf_set_s;
    logic             map_wr_s;
    logic             ctrl_wr_s;
    logic             stat_wr_s;
    logic             commit_s;
    logic [SP_W-1:0]  push_idx_s;
    logic [SP_W-1:0]  pop_idx_s;
    logic [PAGE_W-1:0] sel_page_s;
    logic [11:0]      sel_full_s;
    logic             sel_wp_s;
    logic [7:0]       rd_data_s;

    assign wr_s       = cs & ~rw;
    assign rd_s       = cs & rw;
    assign win_s      = AD[3:1];
    assign hi_sel_s   = AD[0];
    assign page_sel_s = ~AD[4] & ({1'b0, AD[3:1]} < WIN_CNT);

    // Simultaneous enter and exit cancel each other completely.
    assign enter_s    = irq_enter & ~irq_exit;
    assign exit_s     = irq_exit & ~irq_enter;
    assign push_s     = enter_s & (cnt_r < DEPTH);
    assign pop_s      = exit_s & (cnt_r != 3'd0);
    assign ovf_set_s  = enter_s & (cnt_r == DEPTH);
    assign unf_set_s  = exit_s & (cnt_r == 3'd0);

    // Stack activity owns the mapping this cycle; CPU page/wp writes are dropped.
    assign map_wr_s   = wr_s & page_sel_s & ~enter_s & ~pop_s;
    assign ctrl_wr_s  = wr_s & (AD == CTRL_AD);
    assign stat_wr_s  = wr_s & (AD == STATUS_AD);
    assign commit_s   = ctrl_wr_s & DI[2];
    assign push_idx_s = SP_W'(cnt_r);
    assign pop_idx_s  = SP_W'(cnt_r - 3'd1);

    // Next active/shadow page numbers.
    always_comb begin
        act_page_nx_s = act_page_r;
        shd_page_nx_s = shd_page_r;
        if (pop_s) begin
            act_page_nx_s = stk_page_r[pop_idx_s];
            shd_page_nx_s = stk_page_r[pop_idx_s];
        end else if (enter_s) begin
            act_page_nx_s = commit_s ? shd_page_r : act_page_r;
            act_page_nx_s[PAGE_W-1:0] = '0;
            shd_page_nx_s[PAGE_W-1:0] = '0;
        end else begin
            if (commit_s) begin
                act_page_nx_s = shd_page_r;
            end else begin
                act_page_nx_s = act_page_r;
            end
            for (int i = 0; i < WINDOWS; i++) begin
                if (map_wr_s && (win_s == 3'(i))) begin
                    shd_page_nx_s[i*PAGE_W +: PAGE_W] =
                        merge_page(shd_page_r[i*PAGE_W +: PAGE_W], hi_sel_s, DI);
                    act_page_nx_s[i*PAGE_W +: PAGE_W] = shd_mode_r ?
                        act_page_r[i*PAGE_W +: PAGE_W] :
                        merge_page(act_page_r[i*PAGE_W +: PAGE_W], hi_sel_s, DI);
                end else begin
                    shd_page_nx_s[i*PAGE_W +: PAGE_W] = shd_page_r[i*PAGE_W +: PAGE_W];
                end
            end
        end
    end

    // Page state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_page_r <= '0;
            shd_page_r <= '0;
        end else begin
            act_page_r <= act_page_nx_s;
            shd_page_r <= shd_page_nx_s;
        end
    end

    // Saved page sets; only the slot at the current depth is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SLOTS; s++) begin
                stk_page_r[s] <= '0;
            end
        end else if (push_s) begin
            stk_page_r[push_idx_s] <= act_page_r;
        end
    end

`ifdef PAGESEL_MMU_WP_EN
    logic [WINDOWS-1:0] act_wp_r;
    logic [WINDOWS-1:0] shd_wp_r;
    logic [WINDOWS-1:0] act_wp_nx_s;
    logic [WINDOWS-1:0] shd_wp_nx_s;
    logic [WINDOWS-1:0] stk_wp_r [SLOTS];
    logic [WINDOWS-1:0] rd_wp_src_s;

    // Next active/shadow write-protect flags, mirroring the page update rules.
    always_comb begin
        act_wp_nx_s = act_wp_r;
        shd_wp_nx_s = shd_wp_r;
        if (pop_s) begin
            act_wp_nx_s = stk_wp_r[pop_idx_s];
            shd_wp_nx_s = stk_wp_r[pop_idx_s];
        end else if (enter_s) begin
            act_wp_nx_s    = commit_s ? shd_wp_r : act_wp_r;
            act_wp_nx_s[0] = 1'b0;
            shd_wp_nx_s[0] = 1'b0;
        end else begin
            if (commit_s) begin
                act_wp_nx_s = shd_wp_r;
            end else begin
                act_wp_nx_s = act_wp_r;
            end
            for (int i = 0; i < WINDOWS; i++) begin
                if (map_wr_s && hi_sel_s && (win_s == 3'(i))) begin
                    shd_wp_nx_s[i] = DI[6];
                    act_wp_nx_s[i] = shd_mode_r ? act_wp_r[i] : DI[6];
                end else begin
                    shd_wp_nx_s[i] = shd_wp_r[i];
                end
            end
        end
    end

    // Write-protect state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_wp_r <= '0;
            shd_wp_r <= '0;
        end else begin
            act_wp_r <= act_wp_nx_s;
            shd_wp_r <= shd_wp_nx_s;
        end
    end

    // Saved write-protect sets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SLOTS; s++) begin
                stk_wp_r[s] <= '0;
            end
        end else if (push_s) begin
            stk_wp_r[push_idx_s] <= act_wp_r;
        end
    end

    // Write-protect flag of the addressed window for readback.
    always_comb begin
        rd_wp_src_s = shd_mode_r ? shd_wp_r : act_wp_r;
        sel_wp_s    = 1'b0;
        for (int i = 0; i < WINDOWS; i++) begin
            sel_wp_s = (win_s == 3'(i)) ? rd_wp_src_s[i] : sel_wp_s;
        end
    end

    assign wp = act_wp_r;
`else
    assign sel_wp_s = 1'b0;
    assign wp       = '0;
`endif

    // Control, stack depth and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_r     <= 1'b0;
            shd_mode_r <= 1'b0;
            cnt_r      <= 3'd0;
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                bram_r     <= DI[0];
                shd_mode_r <= DI[1];
            end
            if (push_s) begin
                cnt_r <= cnt_r + 3'd1;
            end else if (pop_s) begin
                cnt_r <= cnt_r - 3'd1;
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (stat_wr_s && DI[6]) begin
                ovf_r <= 1'b0;
            end
            if (unf_set_s) begin
                unf_r <= 1'b1;
            end else if (stat_wr_s && DI[7]) begin
                unf_r <= 1'b0;
            end
        end
    end

    // Page number of the addressed window; shadow mode reads the shadow copy.
    always_comb begin
        rd_src_s   = shd_mode_r ? shd_page_r : act_page_r;
        sel_page_s = '0;
        for (int i = 0; i < WINDOWS; i++) begin
            sel_page_s = (win_s == 3'(i)) ? rd_src_s[i*PAGE_W +: PAGE_W] : sel_page_s;
        end
        sel_full_s = widen(sel_page_s);
    end

    // Register read multiplexer.
    always_comb begin
        rd_data_s = 8'h00;
        if (page_sel_s) begin
            if (hi_sel_s) begin
                rd_data_s = {1'b0, sel_wp_s, 2'b00, sel_full_s[11:8]};
            end else begin
                rd_data_s = sel_full_s[7:0];
            end
        end else begin
            case (AD)
                CTRL_AD:   rd_data_s = {6'b000000, shd_mode_r, bram_r};
                STATUS_AD: rd_data_s = {unf_r, ovf_r, 3'b000, cnt_r};
                default:   rd_data_s = 8'h00;
            endcase
        end
    end

    // Read data register, held between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            do_r <= 8'h00;
        end else if (rd_s) begin
            do_r <= rd_data_s;
        end
    end

    assign DO           = do_r;
    assign page         = act_page_r;
    assign bram_disable = bram_r;

endmodule

// File: tb/tb_pagesel_mmu.sv
// Self-checking bench for pagesel_mmu (PAGE_W=12, WINDOWS=4, STACK_DEPTH=4);
// read data is checked through a scoreboard of expected DO values.
module tb_pagesel_mmu;

    localparam int PAGE_W      = 12;
    localparam int WINDOWS     = 4;
    localparam int STACK_DEPTH = 4;
`ifdef PAGESEL_MMU_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic                       clk;
    logic                       rst_n;
    logic [4:0]                 AD;
    logic [7:0]                 DI;
    logic [7:0]                 DO;
    logic                       rw;
    logic                       cs;
    logic                       irq_enter;
    logic                       irq_exit;
    logic [WINDOWS*PAGE_W-1:0]  page;
    logic [WINDOWS-1:0]         wp;
    logic                       bram_disable;

    int          n_cmp;
    int          n_err;
    logic [7:0]  sb_q [$];
    logic        rd_vld;

    pagesel_mmu #(
        .PAGE_W      (PAGE_W),
        .WINDOWS     (WINDOWS),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .AD           (AD),
        .DI           (DI),
        .DO           (DO),
        .rw           (rw),
        .cs           (cs),
        .irq_enter    (irq_enter),
        .irq_exit     (irq_exit),
        .page         (page),
        .wp           (wp),
        .bram_disable (bram_disable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Remember which edges performed a read so DO is checked one cycle later.
    always @(posedge clk) rd_vld <= cs && rw && rst_n;

    always @(negedge clk) begin
        if (rd_vld) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underrun", 64'd1, 64'd0);
            end else begin
                check_eq("DO", {56'd0, DO}, {56'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic op(input logic en, input logic ex, input logic c, input logic r,
                      input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        irq_enter = en;
        irq_exit  = ex;
        cs        = c;
        rw        = r;
        AD        = a;
        DI        = d;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 1'b0, 1'b1, 5'h00, 8'h00);
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        op(1'b0, 1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] exp);
        op(1'b0, 1'b0, 1'b1, 1'b1, a, 8'h00);
        sb_q.push_back(exp);
    endtask

    task automatic enter();
        op(1'b1, 1'b0, 1'b0, 1'b1, 5'h00, 8'h00);
    endtask

    task automatic leave();
        op(1'b0, 1'b1, 1'b0, 1'b1, 5'h00, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [47:0] m0_page;
        logic [3:0]  m0_wp;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        cs        = 1'b0;
        rw        = 1'b1;
        AD        = 5'h00;
        DI        = 8'h00;
        irq_enter = 1'b0;
        irq_exit  = 1'b0;
        m0_page   = 48'h123_000_005_003;
        m0_wp     = WP ? 4'b0100 : 4'b0000;

        #1;
        check_eq("rst_page", 64'(page), 64'd0);
        check_eq("rst_wp", 64'(wp), 64'd0);
        check_eq("rst_bram", 64'(bram_disable), 64'd0);
        check_eq("rst_do", 64'(DO), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Every register reads zero after reset.
        for (int a = 0; a <= 5'h11; a++) rd(5'(a), 8'h00);
        idle();

        // 12-bit page and write-protect on window 1.
        wr(5'h02, 8'hA5);
        wr(5'h03, 8'h4B);
        idle();
        check_eq("w1_page", 64'(page), 64'h000_000_BA5_000);
        check_eq("w1_wp", 64'(wp), WP ? 64'h2 : 64'h0);
        rd(5'h03, WP ? 8'h4B : 8'h0B);
        rd(5'h02, 8'hA5);

        // Shadow write, then atomic commit.
        wr(5'h10, 8'h02);
        wr(5'h00, 8'h07);
        idle();
        check_eq("shadow_hold", 64'(page), 64'h000_000_BA5_000);
        rd(5'h00, 8'h07);
        wr(5'h10, 8'h06);
        idle();
        check_eq("commit", 64'(page), 64'h000_000_BA5_007);
        rd(5'h10, 8'h02);
        wr(5'h10, 8'h00);

        // Build mapping M0 and do one enter/exit round trip.
        wr(5'h00, 8'h03);
        wr(5'h02, 8'h05);
        wr(5'h03, 8'h00);
        wr(5'h05, 8'h40);
        wr(5'h06, 8'h23);
        wr(5'h07, 8'h01);
        idle();
        check_eq("m0_page", 64'(page), 64'(m0_page));
        check_eq("m0_wp", 64'(wp), 64'(m0_wp));
        enter();
        idle();
        check_eq("enter_page", 64'(page), 64'h123_000_005_000);
        rd(5'h11, 8'h01);
        wr(5'h02, 8'h09);
        idle();
        check_eq("irq_write", 64'(page), 64'h123_000_009_000);
        leave();
        idle();
        check_eq("exit_page", 64'(page), 64'(m0_page));
        check_eq("exit_wp", 64'(wp), 64'(m0_wp));
        rd(5'h11, 8'h00);

        // Five enters: first drops a same-cycle page write, fifth overflows
        // while a same-cycle ovf clear is attempted.
        op(1'b1, 1'b0, 1'b1, 1'b0, 5'h02, 8'h77);
        idle();
        check_eq("push_drops_wr", 64'(page), 64'h123_000_005_000);
        enter();
        enter();
        enter();
        op(1'b1, 1'b0, 1'b1, 1'b0, 5'h11, 8'h40);
        idle();
        check_eq("ovf_page", 64'(page), 64'h123_000_005_000);
        check_eq("ovf_wp", 64'(wp), WP ? 64'h4 : 64'h0);
        rd(5'h11, 8'h44);
        wr(5'h11, 8'h40);
        rd(5'h11, 8'h04);
        leave();
        leave();
        leave();
        idle();
        check_eq("pop3_page", 64'(page), 64'h123_000_005_000);
        leave();
        leave();
        idle();
        check_eq("unf_page", 64'(page), 64'(m0_page));
        check_eq("unf_wp", 64'(wp), 64'(m0_wp));
        rd(5'h11, 8'h80);
        wr(5'h11, 8'h80);
        rd(5'h11, 8'h00);

        // Asynchronous reset from a stacked state.
        wr(5'h10, 8'h01);
        enter();
        enter();
        rd(5'h11, 8'h02);
        idle();
        check_eq("pre_rst_bram", 64'(bram_disable), 64'd1);
        check_eq("pre_rst_page", 64'(page), 64'h123_000_005_000);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_page", 64'(page), 64'd0);
        check_eq("arst_wp", 64'(wp), 64'd0);
        check_eq("arst_bram", 64'(bram_disable), 64'd0);
        check_eq("arst_do", 64'(DO), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Enter and exit together is a no-op.
        enter();
        wr(5'h00, 8'h06);
        op(1'b1, 1'b1, 1'b0, 1'b1, 5'h00, 8'h00);
        idle();
        check_eq("both_irq_page", 64'(page), 64'h6);
        rd(5'h11, 8'h01);
        idle();
        idle();
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
